// File: rtl/tt_pkg.sv
// +----------------------------------------------------------------------------+
// | tt_pkg : shared FSM states, bank word addresses and sequence comparison     |
// | Revision: 1.0                                                                |
// +----------------------------------------------------------------------------+
`default_nettype none

package tt_pkg;

   localparam int unsigned TT_SEQ_W     = 32;
   localparam int unsigned TT_TS_A_ADDR  = 2;
   localparam int unsigned TT_SEQ_A_ADDR = 4;
   localparam int unsigned TT_TS_B_ADDR  = 8;
   localparam int unsigned TT_SEQ_B_ADDR = 10;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_RD_SEQ_A = 3'd1,
      ST_RD_SEQ_B = 3'd2,
      ST_CHOOSE   = 3'd3,
      ST_RD_TS    = 3'd4,
      ST_LOAD     = 3'd5
   } tt_state_e;

   // True when a is strictly ahead of b in wrap-around sequence space.
   function automatic logic seq_newer(input logic [TT_SEQ_W-1:0] a,
                                      input logic [TT_SEQ_W-1:0] b);
      logic [TT_SEQ_W-1:0] diff;
      diff = a - b;
      return (!diff[TT_SEQ_W-1]) && (diff != '0);
   endfunction

endpackage

`default_nettype wire

// File: rtl/tt_ram_reader.sv
// +----------------------------------------------------------------------------+
// | tt_ram_reader : one outstanding payload RAM read, RD_LAT cycle pipeline     |
// | Revision: 1.0                                                                |
// +----------------------------------------------------------------------------+
`default_nettype none

module tt_ram_reader #(
   parameter int ADDR_W = 9,
   parameter int DATA_W = 32,
   parameter int RD_LAT = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_req,
   input  logic [ADDR_W-1:0] i_req_addr,
   output logic [ADDR_W-1:0] o_ram_rd_addr,
   input  logic [DATA_W-1:0] i_ram_rd_data,
   output logic              o_done,
   output logic              o_data_valid,
   output logic [DATA_W-1:0] o_data
);

   localparam int CNT_W = (RD_LAT > 1) ? $clog2(RD_LAT + 1) : 1;

   logic              active_q, active_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] data_q, data_d;
   logic              valid_q, valid_d;
   logic              w_done;

   // Last cycle of a read: RAM data for the issued address is on the bus now.
   assign w_done = active_q && (cnt_q == '0);

   always_comb begin
      active_d = active_q;
      cnt_d    = cnt_q;
      addr_d   = addr_q;
      data_d   = data_q;
      valid_d  = w_done;
      if (w_done) begin
         active_d = 1'b0;
         data_d   = i_ram_rd_data;
      end else if (active_q) begin
         cnt_d = cnt_q - CNT_W'(1);
      end
      if (i_req) begin
         active_d = 1'b1;
         cnt_d    = CNT_W'(RD_LAT);
         addr_d   = i_req_addr;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         active_q <= 1'b0;
         cnt_q    <= '0;
         addr_q   <= '0;
         data_q   <= '0;
         valid_q  <= 1'b0;
      end else begin
         active_q <= active_d;
         cnt_q    <= cnt_d;
         addr_q   <= addr_d;
         data_q   <= data_d;
         valid_q  <= valid_d;
      end
   end

   assign o_ram_rd_addr = addr_q;
   assign o_done        = w_done;
   assign o_data_valid  = valid_q;
   assign o_data        = data_q;

endmodule

`default_nettype wire

// File: rtl/tt_sync_rx.sv
// +----------------------------------------------------------------------------+
// | tt_sync_rx : reads both timestamp banks of a received frame, picks the     |
// |              newest, rejects stale frames and reloads the local time.       |
// | Revision: 1.0                                                                |
// +----------------------------------------------------------------------------+
`default_nettype none

module tt_sync_rx
   import tt_pkg::*;
#(
   parameter int ADDR_W     = 9,
   parameter int DATA_W     = 32,
   parameter int RD_LAT     = 1,
   parameter int TS_A_ADDR  = TT_TS_A_ADDR,
   parameter int SEQ_A_ADDR = TT_SEQ_A_ADDR,
   parameter int TS_B_ADDR  = TT_TS_B_ADDR,
   parameter int SEQ_B_ADDR = TT_SEQ_B_ADDR,
   parameter int LINK_DELAY = 0
) (
   input  logic              e_rxc,
   input  logic              reset,
   input  logic              sync_en,
   input  logic              data_receive,
   output logic [ADDR_W-1:0] ram_rd_addr,
   input  logic [DATA_W-1:0] ram_rd_data,
   output logic [DATA_W-1:0] time_counter,
   output logic              sync_valid,
   output logic              stale_pulse,
   output logic [DATA_W-1:0] last_seq,
   output logic [DATA_W-1:0] offset,
   output logic              busy,
   output logic [7:0]        drop_cnt
);

   // Cycles from trigger to LOAD; the timestamp aged this much before it lands.
   localparam int                PROC_LAT = 3 * (RD_LAT + 1) + 2;
   localparam logic [DATA_W-1:0] LOAD_ADJ = DATA_W'(LINK_DELAY + PROC_LAT);

   tt_state_e         state_q, state_d;
   logic              dr_q, dr_d;
   logic [DATA_W-1:0] seq_a_q, seq_a_d;
   logic [DATA_W-1:0] seq_sel_q, seq_sel_d;
   logic              sync_valid_q, sync_valid_d;
   logic              stale_q, stale_d;
   logic [DATA_W-1:0] tc_q, tc_d;
   logic [DATA_W-1:0] last_seq_q, last_seq_d;
   logic [DATA_W-1:0] offset_q, offset_d;
   logic              have_sync_q, have_sync_d;
   logic [7:0]        drop_q, drop_d;

   logic              w_trig;
   logic              rd_req;
   logic [ADDR_W-1:0] rd_req_addr;
   logic              rd_done;
   logic              rd_valid;
   logic [DATA_W-1:0] rd_data;
   logic [DATA_W-1:0] w_load;

   tt_ram_reader #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W),
      .RD_LAT (RD_LAT)
   ) u_reader (
      .clk           (e_rxc),
      .rst           (reset),
      .i_req         (rd_req),
      .i_req_addr    (rd_req_addr),
      .o_ram_rd_addr (ram_rd_addr),
      .i_ram_rd_data (ram_rd_data),
      .o_done        (rd_done),
      .o_data_valid  (rd_valid),
      .o_data        (rd_data)
   );

   assign w_trig = data_receive & ~dr_q;
   assign w_load = rd_data + LOAD_ADJ;

   always_comb begin
      state_d      = state_q;
      dr_d         = data_receive;
      seq_a_d      = seq_a_q;
      seq_sel_d    = seq_sel_q;
      sync_valid_d = 1'b0;
      stale_d      = 1'b0;
      tc_d         = tc_q + DATA_W'(1);
      last_seq_d   = last_seq_q;
      offset_d     = offset_q;
      have_sync_d  = have_sync_q;
      drop_d       = drop_q;
      rd_req       = 1'b0;
      rd_req_addr  = ADDR_W'(SEQ_A_ADDR);

      if (w_trig && sync_en && (state_q != ST_IDLE) && (drop_q != 8'hFF))
         drop_d = drop_q + 8'd1;

      case (state_q)
         ST_IDLE: begin
            if (w_trig && sync_en) begin
               rd_req  = 1'b1;
               state_d = ST_RD_SEQ_A;
            end
         end
         ST_RD_SEQ_A: begin
            if (rd_done) begin
               rd_req      = 1'b1;
               rd_req_addr = ADDR_W'(SEQ_B_ADDR);
               state_d     = ST_RD_SEQ_B;
            end
         end
         ST_RD_SEQ_B: begin
            if (rd_valid)
               seq_a_d = rd_data;
            if (rd_done)
               state_d = ST_CHOOSE;
         end
         ST_CHOOSE: begin
            // Reader output holds sequence B here; a tie falls back to bank A.
            rd_req = 1'b1;
            if (seq_newer(rd_data, seq_a_q)) begin
               seq_sel_d   = rd_data;
               rd_req_addr = ADDR_W'(TS_B_ADDR);
            end else begin
               seq_sel_d   = seq_a_q;
               rd_req_addr = ADDR_W'(TS_A_ADDR);
            end
            state_d = ST_RD_TS;
         end
         ST_RD_TS: begin
            if (rd_done) begin
               sync_valid_d = !have_sync_q || seq_newer(seq_sel_q, last_seq_q);
               stale_d      = !sync_valid_d;
               state_d      = ST_LOAD;
            end
         end
         ST_LOAD: begin
            // sync_valid_q doubles as the accept decision for this frame.
            if (sync_valid_q) begin
               tc_d        = w_load;
               offset_d    = w_load - (tc_q + DATA_W'(1));
               last_seq_d  = seq_sel_q;
               have_sync_d = 1'b1;
            end
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge e_rxc or posedge reset) begin
      if (reset) begin
         state_q      <= ST_IDLE;
         dr_q         <= 1'b0;
         seq_a_q      <= '0;
         seq_sel_q    <= '0;
         sync_valid_q <= 1'b0;
         stale_q      <= 1'b0;
         tc_q         <= '0;
         last_seq_q   <= '0;
         offset_q     <= '0;
         have_sync_q  <= 1'b0;
         drop_q       <= 8'd0;
      end else begin
         state_q      <= state_d;
         dr_q         <= dr_d;
         seq_a_q      <= seq_a_d;
         seq_sel_q    <= seq_sel_d;
         sync_valid_q <= sync_valid_d;
         stale_q      <= stale_d;
         tc_q         <= tc_d;
         last_seq_q   <= last_seq_d;
         offset_q     <= offset_d;
         have_sync_q  <= have_sync_d;
         drop_q       <= drop_d;
      end
   end

   assign time_counter = tc_q;
   assign sync_valid   = sync_valid_q;
   assign stale_pulse  = stale_q;
   assign last_seq     = last_seq_q;
   assign offset       = offset_q;
   assign busy         = (state_q != ST_IDLE);
   assign drop_cnt     = drop_q;

endmodule

`default_nettype wire

// File: tb/tb_tt_sync_rx.sv
// +----------------------------------------------------------------------------+
// | tb_tt_sync_rx : directed bench for tt_sync_rx, two instances sharing        |
// |                 stimulus with LINK_DELAY 0 and 4.                           |
// | Revision: 1.0                                                                |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_tt_sync_rx;

   logic        clk = 1'b0;
   logic        reset;
   logic        sync_en;
   logic        data_receive;
   logic [31:0] mem [0:511];

   logic [8:0]  addr0, addr1;
   logic [31:0] rd_data0, rd_data1;
   logic [31:0] tc0, tc1, last_seq0, last_seq1, offset0, offset1;
   logic        sv0, sv1, stale0, stale1, busy0, busy1;
   logic [7:0]  drop0, drop1;

   logic [31:0] exp_tc0, exp_tc1;
   int          n_checks = 0;
   int          n_pass   = 0;

   always #5 clk = ~clk;

   always @(posedge clk) begin
      rd_data0 <= mem[addr0];
      rd_data1 <= mem[addr1];
   end

   tt_sync_rx #(.LINK_DELAY(0)) u_dut0 (
      .e_rxc(clk), .reset(reset), .sync_en(sync_en), .data_receive(data_receive),
      .ram_rd_addr(addr0), .ram_rd_data(rd_data0), .time_counter(tc0),
      .sync_valid(sv0), .stale_pulse(stale0), .last_seq(last_seq0),
      .offset(offset0), .busy(busy0), .drop_cnt(drop0)
   );

   tt_sync_rx #(.LINK_DELAY(4)) u_dut1 (
      .e_rxc(clk), .reset(reset), .sync_en(sync_en), .data_receive(data_receive),
      .ram_rd_addr(addr1), .ram_rd_data(rd_data1), .time_counter(tc1),
      .sync_valid(sv1), .stale_pulse(stale1), .last_seq(last_seq1),
      .offset(offset1), .busy(busy1), .drop_cnt(drop1)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %h, expected %h", tag, obs, exp);
   endtask

   // One clock: the free-running reference counts unless reset was held at the edge.
   task automatic tick();
      @(posedge clk);
      if (!reset) begin
         exp_tc0 = exp_tc0 + 32'd1;
         exp_tc1 = exp_tc1 + 32'd1;
      end
      #1;
   endtask

   task automatic run_frame(input string tag,
                            input logic [31:0] sa, input logic [31:0] sb,
                            input logic [31:0] ta, input logic [31:0] tb,
                            input bit use_b, input bit ok, input logic [31:0] exp_seq,
                            input logic [31:0] ld0, input logic [31:0] ld1,
                            input bit overrun);
      logic [31:0] off0, off1;
      mem[4] = sa; mem[10] = sb; mem[2] = ta; mem[8] = tb;
      tick(); data_receive = 1'b1;                          // cycle T
      check({tag, "/busy_T"}, {31'd0, busy0}, 32'd0);
      tick(); data_receive = 1'b0;                          // T+1
      check({tag, "/busy_T1"}, {31'd0, busy0}, 32'd1);
      check({tag, "/addr_seqA"}, {23'd0, addr0}, 32'd4);
      tick(); tick(); data_receive = overrun;               // T+3
      check({tag, "/addr_seqB"}, {23'd0, addr0}, 32'd10);
      tick(); data_receive = 1'b0; tick(); tick();          // T+6
      check({tag, "/addr_ts"}, {23'd0, addr0}, use_b ? 32'd8 : 32'd2);
      tick(); tick();                                       // T+8
      check({tag, "/sync_valid"}, {31'd0, sv0}, {31'd0, ok});
      check({tag, "/stale"}, {31'd0, stale0}, {31'd0, !ok});
      off0 = ld0 - (exp_tc0 + 32'd1);
      off1 = ld1 - (exp_tc1 + 32'd1);
      tick();                                               // T+9
      if (ok) begin
         exp_tc0 = ld0;
         exp_tc1 = ld1;
         check({tag, "/offset0"}, offset0, off0);
         check({tag, "/offset1"}, offset1, off1);
      end
      check({tag, "/tc0"}, tc0, exp_tc0);
      check({tag, "/tc1"}, tc1, exp_tc1);
      check({tag, "/last_seq"}, last_seq0, exp_seq);
      check({tag, "/pulse_gone"}, {30'd0, sv0, stale0}, 32'd0);
      check({tag, "/idle"}, {31'd0, busy0}, 32'd0);
   endtask

   initial begin
      for (int i = 0; i < 512; i++) mem[i] = 32'd0;
      reset = 1'b1; sync_en = 1'b1; data_receive = 1'b0;
      exp_tc0 = 32'd0; exp_tc1 = 32'd0;
      tick(); tick(); tick();
      check("rst/tc", tc0, 32'd0);
      check("rst/busy", {31'd0, busy0}, 32'd0);
      check("rst/addr", {23'd0, addr0}, 32'd0);
      check("rst/drop", {24'd0, drop0}, 32'd0);
      check("rst/last_seq", last_seq0, 32'd0);
      check("rst/pulses", {30'd0, sv0, stale0}, 32'd0);
      reset = 1'b0;
      tick(); tick();
      check("run/tc", tc0, exp_tc0);

      run_frame("f1_bankA", 32'd2, 32'd0, 32'h1000, 32'hDEAD, 1'b0, 1'b1, 32'd2,
                32'h1008, 32'h100C, 1'b0);
      run_frame("f2_bankB", 32'd2, 32'd3, 32'h1111, 32'h5000, 1'b1, 1'b1, 32'd3,
                32'h5008, 32'h500C, 1'b0);
      run_frame("f3_stale", 32'd2, 32'd1, 32'h1234, 32'h5678, 1'b0, 1'b0, 32'd3,
                32'h0, 32'h0, 1'b0);
      run_frame("f4_overrun", 32'd6, 32'd5, 32'h2000, 32'hBBBB, 1'b0, 1'b1, 32'd6,
                32'h2008, 32'h200C, 1'b1);
      check("overrun/drop", {24'd0, drop0}, 32'd1);

      tick(); sync_en = 1'b0; data_receive = 1'b1;
      tick();
      check("dis/busy", {31'd0, busy0}, 32'd0);
      data_receive = 1'b0;
      tick();
      check("dis/busy2", {31'd0, busy0}, 32'd0);
      check("dis/drop", {24'd0, drop0}, 32'd1);
      check("dis/tc", tc0, exp_tc0);
      sync_en = 1'b1;

      // Abort a frame mid-flight with an asynchronous reset.
      mem[4] = 32'd8; mem[10] = 32'd7;
      tick(); data_receive = 1'b1;
      tick(); data_receive = 1'b0;
      tick(); tick(); tick();
      check("mid/busy_before", {31'd0, busy0}, 32'd1);
      #2 reset = 1'b1; exp_tc0 = 32'd0; exp_tc1 = 32'd0;
      #1;
      check("mid/busy", {31'd0, busy0}, 32'd0);
      check("mid/addr", {23'd0, addr0}, 32'd0);
      check("mid/tc", tc0, 32'd0);
      check("mid/last_seq", last_seq0, 32'd0);
      check("mid/drop", {24'd0, drop0}, 32'd0);
      tick(); reset = 1'b0;
      tick(); tick();

      run_frame("f5_first", 32'hFFFFFFFE, 32'hFFFFFFFF, 32'h7777, 32'h3000, 1'b1, 1'b1,
                32'hFFFFFFFF, 32'h3008, 32'h300C, 1'b0);
      run_frame("f6_wrap", 32'h00000000, 32'hFFFFFFFE, 32'h4000, 32'h9999, 1'b0, 1'b1,
                32'h0, 32'h4008, 32'h400C, 1'b0);
      run_frame("f7_tie", 32'd4, 32'd4, 32'h6000, 32'hAAAA, 1'b0, 1'b1, 32'd4,
                32'h6008, 32'h600C, 1'b0);
      check("end/drop", {24'd0, drop0}, 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

`default_nettype wire
